// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM states
// and the byte-lane helpers used by both the control path and the load aligner.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_t;

   function automatic logic [3:0] lsu_byte_en(input logic [2:0] funct3, input logic [1:0] a);
      logic [3:0] be;
      case (funct3)
         F3_B, F3_BU: be = 4'b0001 << a;
         F3_H, F3_HU: be = 4'b0011 << {a[1], 1'b0};
         F3_W:        be = 4'b1111;
         default:     be = 4'b0000;
      endcase
      return be;
   endfunction

   // Unsigned loads have no store counterpart, so BU/HU are legal only for loads.
   function automatic logic lsu_is_legal(input logic [2:0] funct3, input logic we);
      logic ok;
      case (funct3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = !we;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] a);
      logic mis;
      case (funct3)
         F3_H, F3_HU: mis = a[0];
         F3_W:        mis = (a != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Rounds the byte offset down to the natural boundary of the access size.
   function automatic logic [1:0] lsu_align_off(input logic [2:0] funct3, input logic [1:0] a);
      logic [1:0] off;
      case (funct3)
         F3_H, F3_HU: off = {a[1], 1'b0};
         F3_W:        off = 2'b00;
         default:     off = a;
      endcase
      return off;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: picks the byte/half lane out of the memory word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_off,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
   assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

   // NOTE: o_data gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      o_data = '0;
      case (i_funct3)
         F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_data = {24'd0, w_byte};
         F3_H:    o_data = {{16{w_half[15]}}, w_half};
         F3_HU:   o_data = {16'd0, w_half};
         F3_W:    o_data = i_rdata;
         default: o_data = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE->ACCESS->RESP handshake to a word-wide data memory.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses instead of forcing alignment.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DWIDTH   = 32,
   parameter int AWIDTH   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic              Clk,
   input  logic              Rst_N,
   input  logic              LSU_Req,
   input  logic              LSU_We,
   input  logic [2:0]        LSU_Funct3,
   input  logic [AWIDTH-1:0] LSU_Addr,
   input  logic [DWIDTH-1:0] LSU_Wdata,
   output logic [DWIDTH-1:0] LSU_Rdata,
   output logic              LSU_Done,
   output logic              LSU_Err,
   output logic              LSU_Busy,
   output logic              Mem_Req,
   output logic              Mem_We,
   output logic [AWIDTH-1:0] Mem_Addr,
   output logic [3:0]        Mem_Be,
   output logic [DWIDTH-1:0] Mem_Wdata,
   input  logic              Mem_Ack,
   input  logic [DWIDTH-1:0] Mem_Rdata
);

   localparam int WCW = $clog2(MAX_WAIT + 1);

   lsu_state_t        r_state;
   lsu_state_t        w_next;
   logic              r_we;
   logic [2:0]        r_f3;
   logic [AWIDTH-3:0] r_waddr;
   logic [1:0]        r_off;
   logic [DWIDTH-1:0] r_wdata;
   logic [WCW-1:0]    r_wait;
   logic [DWIDTH-1:0] r_rdata;
   logic              r_err;

   logic              w_reject;
   logic [1:0]        w_off_in;
   logic              w_timeout;
   logic              w_access;
   logic [DWIDTH-1:0] w_load_data;
   logic [DWIDTH-1:0] w_store_lanes;

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_reject = !lsu_is_legal(LSU_Funct3, LSU_We) || lsu_misaligned(LSU_Funct3, LSU_Addr[1:0]);
`else
   assign w_reject = !lsu_is_legal(LSU_Funct3, LSU_We);
`endif
   assign w_off_in  = lsu_align_off(LSU_Funct3, LSU_Addr[1:0]);
   assign w_timeout = (r_wait == WCW'(MAX_WAIT - 1));
   assign w_access  = (r_state == ACCESS);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (LSU_Req) w_next = w_reject ? RESP : ACCESS;
         ACCESS:  if (Mem_Ack || w_timeout) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // NOTE: state and capture registers use non-blocking assignments so every flop samples pre-edge values.
   // Capture registers are reset too: they drive outputs that must read 0 straight out of reset.
   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) begin
         r_state <= IDLE;
         r_we    <= 1'b0;
         r_f3    <= '0;
         r_waddr <= '0;
         r_off   <= '0;
         r_wdata <= '0;
         r_wait  <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: begin
               if (LSU_Req) begin
                  r_we    <= LSU_We;
                  r_f3    <= LSU_Funct3;
                  r_waddr <= LSU_Addr[AWIDTH-1:2];
                  r_off   <= w_off_in;
                  r_wdata <= LSU_Wdata;
                  r_wait  <= '0;
                  r_err   <= w_reject;
                  if (w_reject) r_rdata <= '0;
               end
            end
            ACCESS: begin
               if (Mem_Ack) begin
                  r_err <= 1'b0;
                  if (!r_we) r_rdata <= w_load_data;
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_rdata <= '0;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   lsu_load_align u_load_align (
      .i_rdata  (Mem_Rdata),
      .i_funct3 (r_f3),
      .i_off    (r_off),
      .o_data   (w_load_data)
   );

   always_comb begin
      w_store_lanes = r_wdata;
      case (r_f3)
         F3_B:    w_store_lanes = {4{r_wdata[7:0]}};
         F3_H:    w_store_lanes = {2{r_wdata[15:0]}};
         default: w_store_lanes = r_wdata;
      endcase
   end

   // Memory port is driven only while in ACCESS so it idles at zero.
   assign Mem_Req   = w_access;
   assign Mem_We    = w_access & r_we;
   assign Mem_Addr  = w_access ? {r_waddr, 2'b00} : '0;
   assign Mem_Be    = w_access ? lsu_byte_en(r_f3, r_off) : 4'b0000;
   assign Mem_Wdata = w_access ? w_store_lanes : '0;

   assign LSU_Done  = (r_state == RESP);
   assign LSU_Err   = LSU_Done & r_err;
   assign LSU_Busy  = (r_state != IDLE);
   assign LSU_Rdata = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions against a byte-level reference model (honours LSU_MISALIGN_TRAP_EN).
module tb_load_store_unit;

   logic        Clk;
   logic        Rst_N;
   logic        LSU_Req;
   logic        LSU_We;
   logic [2:0]  LSU_Funct3;
   logic [31:0] LSU_Addr;
   logic [31:0] LSU_Wdata;
   logic [31:0] LSU_Rdata;
   logic        LSU_Done;
   logic        LSU_Err;
   logic        LSU_Busy;
   logic        Mem_Req;
   logic        Mem_We;
   logic [31:0] Mem_Addr;
   logic [3:0]  Mem_Be;
   logic [31:0] Mem_Wdata;
   logic        Mem_Ack;
   logic [31:0] Mem_Rdata;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_rdata = '0;

   load_store_unit #(.DWIDTH(32), .AWIDTH(32), .MAX_WAIT(15)) dut (
      .Clk        (Clk),
      .Rst_N      (Rst_N),
      .LSU_Req    (LSU_Req),
      .LSU_We     (LSU_We),
      .LSU_Funct3 (LSU_Funct3),
      .LSU_Addr   (LSU_Addr),
      .LSU_Wdata  (LSU_Wdata),
      .LSU_Rdata  (LSU_Rdata),
      .LSU_Done   (LSU_Done),
      .LSU_Err    (LSU_Err),
      .LSU_Busy   (LSU_Busy),
      .Mem_Req    (Mem_Req),
      .Mem_We     (Mem_We),
      .Mem_Addr   (Mem_Addr),
      .Mem_Be     (Mem_Be),
      .Mem_Wdata  (Mem_Wdata),
      .Mem_Ack    (Mem_Ack),
      .Mem_Rdata  (Mem_Rdata)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Byte-level reference: access size, natural alignment, lane replication and extension.
   function automatic void ref_model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [31:0] rword,
                                     output bit goes_to_mem, output logic [3:0] be,
                                     output logic [31:0] mwdata, output logic [31:0] load_val);
      int size, a, off;
      bit legal, mis;
      logic [31:0] mask;
      legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
      size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      a     = int'(addr[1:0]);
      mis   = (a % size) != 0;
      off   = a - (a % size);
      goes_to_mem = legal;
`ifdef LSU_MISALIGN_TRAP_EN
      if (mis) goes_to_mem = 1'b0;
`endif
      be = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) mwdata[8*i +: 8] = wdata[8*(i % size) +: 8];
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      load_val = (rword >> (8 * off)) & mask;
      if (!f3[2] && load_val[8*size-1]) load_val = load_val | ~mask;
   endfunction

   // One full transaction; ack arrives in ACCESS cycle delay+1 (delay>=15 means never).
   // A stray LSU_Req is also raised during RESP to confirm it is ignored.
   task automatic run_txn(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rword, input int delay);
      bit          to_mem;
      logic [3:0]  e_be;
      logic [31:0] e_wdata, e_load;
      int          held, cyc, exp_held;
      logic        e_err;
      ref_model(we, f3, addr, wdata, rword, to_mem, e_be, e_wdata, e_load);

      @(negedge Clk);
      LSU_Req = 1'b1; LSU_We = we; LSU_Funct3 = f3; LSU_Addr = addr; LSU_Wdata = wdata;
      @(posedge Clk); #1;
      LSU_Req = 1'b0; LSU_We = 1'($urandom); LSU_Funct3 = 3'($urandom);
      LSU_Addr = $urandom; LSU_Wdata = $urandom;
      @(negedge Clk);
      cyc = 1;
      if (to_mem) begin
         check({tag, "/mem_req"},  32'(Mem_Req), 32'd1);
         check({tag, "/mem_addr"}, Mem_Addr, {addr[31:2], 2'b00});
         check({tag, "/mem_be"},   32'(Mem_Be), 32'(e_be));
         check({tag, "/mem_we"},   32'(Mem_We), 32'(we));
         if (we) check({tag, "/mem_wdata"}, Mem_Wdata, e_wdata);
         check({tag, "/busy"},     32'(LSU_Busy), 32'd1);
         held = 0;
         while (Mem_Req === 1'b1 && held < 40) begin
            held++;
            if (held == delay + 1) begin Mem_Ack = 1'b1; Mem_Rdata = rword; end
            @(posedge Clk); #1;
            Mem_Ack = 1'b0; Mem_Rdata = $urandom;
            @(negedge Clk);
            cyc++;
         end
         exp_held = (delay < 15) ? delay + 1 : 15;
         check({tag, "/req_cycles"}, 32'(held), 32'(exp_held));
         check({tag, "/latency"},    32'(cyc), 32'(exp_held + 1));
         e_err = (delay >= 15);
      end else begin
         check({tag, "/no_mem_req"}, 32'(Mem_Req), 32'd0);
         e_err = 1'b1;
      end
      if (e_err) exp_rdata = '0;
      else if (!we) exp_rdata = e_load;
      check({tag, "/done"},  32'(LSU_Done), 32'd1);
      check({tag, "/err"},   32'(LSU_Err), 32'(e_err));
      check({tag, "/rdata"}, LSU_Rdata, exp_rdata);
      check({tag, "/busy_resp"}, 32'(LSU_Busy), 32'd1);
      LSU_Req = 1'b1;
      @(posedge Clk); #1;
      LSU_Req = 1'b0;
      @(negedge Clk);
      check({tag, "/done_pulse"}, 32'(LSU_Done), 32'd0);
      check({tag, "/idle_busy"},  32'(LSU_Busy), 32'd0);
      check({tag, "/idle_req"},   32'(Mem_Req), 32'd0);
      check({tag, "/rdata_hold"}, LSU_Rdata, exp_rdata);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "/rdata"},     LSU_Rdata, 32'd0);
      check({tag, "/done"},      32'(LSU_Done), 32'd0);
      check({tag, "/err"},       32'(LSU_Err), 32'd0);
      check({tag, "/busy"},      32'(LSU_Busy), 32'd0);
      check({tag, "/mem_req"},   32'(Mem_Req), 32'd0);
      check({tag, "/mem_we"},    32'(Mem_We), 32'd0);
      check({tag, "/mem_addr"},  Mem_Addr, 32'd0);
      check({tag, "/mem_be"},    32'(Mem_Be), 32'd0);
      check({tag, "/mem_wdata"}, Mem_Wdata, 32'd0);
   endtask

   initial begin
      Rst_N = 1'b0; LSU_Req = 1'b0; LSU_We = 1'b0; LSU_Funct3 = '0;
      LSU_Addr = '0; LSU_Wdata = '0; Mem_Ack = 1'b0; Mem_Rdata = '0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check_all_zero("reset");
      @(posedge Clk); #1;
      Rst_N = 1'b1;

      run_txn("lw_0x100",   1'b0, 3'b010, 32'h0000_0100, 32'h0,          32'hDEAD_BEEF, 0);
      run_txn("lb_0x103",   1'b0, 3'b000, 32'h0000_0103, 32'h0,          32'h80FF_FF7F, 0);
      run_txn("lbu_0x103",  1'b0, 3'b100, 32'h0000_0103, 32'h0,          32'h80FF_FF7F, 1);
      run_txn("sh_0x102",   1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD,  32'h0,         2);
      run_txn("lw_timeout", 1'b0, 3'b010, 32'h0000_0200, 32'h0,          32'h5555_AAAA, 99);
      run_txn("lw_ack15",   1'b0, 3'b010, 32'h0000_0204, 32'h0,          32'h1357_9BDF, 14);
      run_txn("lh_0x101",   1'b0, 3'b001, 32'h0000_0101, 32'h0,          32'hF00D_8001, 0);
      run_txn("lhu_0x106",  1'b0, 3'b101, 32'h0000_0106, 32'h0,          32'h9ABC_1234, 0);
      run_txn("sb_0x301",   1'b1, 3'b000, 32'h0000_0301, 32'hCAFE_BA5E,  32'h0,         1);
      run_txn("sw_0x300",   1'b1, 3'b010, 32'h0000_0300, 32'h0BAD_F00D,  32'h0,         0);
      run_txn("ill_f3_011", 1'b0, 3'b011, 32'h0000_0400, 32'h0,          32'h0,         0);
      run_txn("ill_sbu",    1'b1, 3'b100, 32'h0000_0400, 32'h1111_1111,  32'h0,         0);
      run_txn("lw_misal",   1'b0, 3'b010, 32'h0000_0502, 32'h0,          32'h8765_4321, 0);

      for (int i = 0; i < 60; i++) begin
         int d;
         d = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
         run_txn($sformatf("rnd%0d", i), 1'($urandom), 3'($urandom_range(0, 7)),
                 $urandom, $urandom, $urandom, d);
      end

      // Reset in the middle of an access, then a stale ack.
      run_txn("pre_rst_lw", 1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'hCAFE_F00D, 0);
      @(negedge Clk);
      LSU_Req = 1'b1; LSU_We = 1'b1; LSU_Funct3 = 3'b010; LSU_Addr = 32'h0000_0700; LSU_Wdata = 32'hFFFF_FFFF;
      @(posedge Clk); #1;
      LSU_Req = 1'b0;
      @(negedge Clk);
      check("mid_rst/pre_req", 32'(Mem_Req), 32'd1);
      #2;
      Rst_N = 1'b0;
      #1;
      check_all_zero("mid_rst");
      @(posedge Clk); #1;
      Rst_N = 1'b1;
      exp_rdata = '0;
      Mem_Ack = 1'b1; Mem_Rdata = 32'h7777_7777;
      @(posedge Clk); #1;
      Mem_Ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         check($sformatf("late_ack/done%0d", k), 32'(LSU_Done), 32'd0);
         check($sformatf("late_ack/busy%0d", k), 32'(LSU_Busy), 32'd0);
         check($sformatf("late_ack/req%0d", k),  32'(Mem_Req), 32'd0);
      end
      run_txn("post_rst_lbu", 1'b0, 3'b100, 32'h0000_0802, 32'h0, 32'h00A5_0000, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
